mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Define MC_CTRL_PERF_EN to add the 32-bit retired-instruction counter output.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        mem_rdy,
    output logic        mem_req,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  NPCOp,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [4:0]  ALUOp,
    output logic        ALUSrc,
    output logic        ARegSel,
    output logic        EXTOp,
    output logic [1:0]  WDSel,
    output logic [1:0]  GPRSel,
    output logic        illegal,
    output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] retired
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;
    localparam logic [4:0] ALU_SLL = 5'd5;
    localparam logic [4:0] ALU_SRL = 5'd6;
    localparam logic [4:0] ALU_LUI = 5'd7;

    localparam logic [4:0] C_ILL  = 5'd0;
    localparam logic [4:0] C_ADD  = 5'd1;
    localparam logic [4:0] C_SUB  = 5'd2;
    localparam logic [4:0] C_AND  = 5'd3;
    localparam logic [4:0] C_OR   = 5'd4;
    localparam logic [4:0] C_SLT  = 5'd5;
    localparam logic [4:0] C_SLL  = 5'd6;
    localparam logic [4:0] C_SRL  = 5'd7;
    localparam logic [4:0] C_ADDI = 5'd8;
    localparam logic [4:0] C_ORI  = 5'd9;
    localparam logic [4:0] C_LUI  = 5'd10;
    localparam logic [4:0] C_LW   = 5'd11;
    localparam logic [4:0] C_SW   = 5'd12;
    localparam logic [4:0] C_BEQ  = 5'd13;
    localparam logic [4:0] C_BNE  = 5'd14;
    localparam logic [4:0] C_J    = 5'd15;
    localparam logic [4:0] C_JAL  = 5'd16;
    localparam logic [4:0] C_JR   = 5'd17;
    localparam logic [4:0] C_JALR = 5'd18;

    function automatic logic [4:0] decode(input logic [5:0] op, input logic [5:0] fn);
        logic [4:0] c;
        c = C_ILL;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   c = C_ADD;
                    6'h22:   c = C_SUB;
                    6'h24:   c = C_AND;
                    6'h25:   c = C_OR;
                    6'h2A:   c = C_SLT;
                    6'h00:   c = C_SLL;
                    6'h02:   c = C_SRL;
                    6'h08:   c = C_JR;
                    6'h09:   c = C_JALR;
                    default: c = C_ILL;
                endcase
            end
            6'h08:   c = C_ADDI;
            6'h0D:   c = C_ORI;
            6'h0F:   c = C_LUI;
            6'h23:   c = C_LW;
            6'h2B:   c = C_SW;
            6'h04:   c = C_BEQ;
            6'h05:   c = C_BNE;
            6'h02:   c = C_J;
            6'h03:   c = C_JAL;
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [4:0] alu_op(input logic [4:0] c);
        logic [4:0] a;
        case (c)
            C_SUB, C_BEQ, C_BNE: a = ALU_SUB;
            C_AND:               a = ALU_AND;
            C_OR, C_ORI:         a = ALU_OR;
            C_SLT:               a = ALU_SLT;
            C_SLL:               a = ALU_SLL;
            C_SRL:               a = ALU_SRL;
            C_LUI:               a = ALU_LUI;
            default:             a = ALU_ADD;
        endcase
        return a;
    endfunction

    logic [2:0] cur;
    logic [2:0] nxt;
    logic [4:0] cls;
    logic [4:0] dec_cls;
    logic       run;

    assign dec_cls = decode(Op, Funct);
    assign state   = cur;

    // run holds every output low from reset until the first edge after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= S_FETCH;
            cls <= C_ILL;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                cur <= nxt;
                if (cur == S_DECODE)
                    cls <= dec_cls;
            end
        end
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: nxt = (dec_cls == C_ILL) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (cls inside {C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SLL, C_SRL,
                                C_ADDI, C_ORI, C_LUI})
                    nxt = S_WB;
                else if (cls inside {C_LW, C_SW})
                    nxt = S_MEM;
                else
                    nxt = S_FETCH;
            end
            S_MEM: begin
                if (!mem_rdy)
                    nxt = S_MEM;
                else
                    nxt = (cls == C_LW) ? S_WB : S_FETCH;
            end
            S_WB:     nxt = S_FETCH;
            default:  nxt = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        NPCOp    = 2'b00;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = ALU_ADD;
        ALUSrc   = 1'b0;
        ARegSel  = 1'b0;
        EXTOp    = 1'b0;
        WDSel    = 2'b00;
        GPRSel   = 2'b00;
        illegal  = 1'b0;
        if (run) begin
            case (cur)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_rdy) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                S_DECODE: illegal = (dec_cls == C_ILL);
                S_EXEC: begin
                    ALUOp   = alu_op(cls);
                    ALUSrc  = cls inside {C_ADDI, C_ORI, C_LUI, C_LW, C_SW};
                    ARegSel = cls inside {C_SLL, C_SRL};
                    EXTOp   = cls inside {C_ADDI, C_LW, C_SW};
                    case (cls)
                        C_BEQ: if (Zero) begin
                            PCWrite = 1'b1;
                            NPCOp   = 2'b01;
                        end
                        C_BNE: if (!Zero) begin
                            PCWrite = 1'b1;
                            NPCOp   = 2'b01;
                        end
                        C_J: begin
                            PCWrite = 1'b1;
                            NPCOp   = 2'b10;
                        end
                        C_JAL: begin
                            PCWrite  = 1'b1;
                            NPCOp    = 2'b10;
                            RegWrite = 1'b1;
                            GPRSel   = 2'b10;
                            WDSel    = 2'b10;
                        end
                        C_JR: begin
                            PCWrite = 1'b1;
                            NPCOp   = 2'b11;
                        end
                        C_JALR: begin
                            PCWrite  = 1'b1;
                            NPCOp    = 2'b11;
                            RegWrite = 1'b1;
                            WDSel    = 2'b10;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = (cls == C_SW);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    if (cls == C_LW) begin
                        GPRSel = 2'b01;
                        WDSel  = 2'b01;
                    end else if (cls inside {C_ADDI, C_ORI, C_LUI}) begin
                        GPRSel = 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    // Only completions out of EXEC/MEM/WB count; illegal exits from DECODE do not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retired <= 32'd0;
        else if (run && nxt == S_FETCH &&
                 (cur == S_EXEC || cur == S_MEM || cur == S_WB))
            retired <= retired + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction expected output vectors are queued
// when an instruction is issued and compared cycle by cycle against the DUT.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  Op = 6'd0;
    logic [5:0]  Funct = 6'd0;
    logic        Zero = 1'b0;
    logic        mem_rdy = 1'b0;
    logic        mem_req, IorD, IRWrite, PCWrite, RegWrite, MemWrite;
    logic [1:0]  NPCOp, WDSel, GPRSel;
    logic [4:0]  ALUOp;
    logic        ALUSrc, ARegSel, EXTOp, illegal;
    logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired;
`endif

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .NPCOp(NPCOp), .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .ARegSel(ARegSel), .EXTOp(EXTOp), .WDSel(WDSel),
        .GPRSel(GPRSel), .illegal(illegal), .state(state)
`ifdef MC_CTRL_PERF_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mrdy;
        logic [23:0] vec;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] exp_ret = 32'd0;
    logic [23:0] obs;

    assign obs = {mem_req, IorD, IRWrite, PCWrite, NPCOp, RegWrite, MemWrite, ALUOp,
                  ALUSrc, ARegSel, EXTOp, WDSel, GPRSel, illegal, state};

    function automatic logic [23:0] mk(input logic mr, input logic iord, input logic irw,
                                       input logic pcw, input logic [1:0] npc, input logic rw,
                                       input logic mw, input logic [4:0] alu, input logic asrc,
                                       input logic arsel, input logic ext, input logic [1:0] wd,
                                       input logic [1:0] gpr, input logic ill, input logic [2:0] st);
        return {mr, iord, irw, pcw, npc, rw, mw, alu, asrc, arsel, ext, wd, gpr, ill, st};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // path: 0 EXEC->FETCH, 1 R-type WB, 2 I-type WB, 3 lw, 4 sw, 5 illegal
    task automatic issue(input string name, input logic zero, input int fwait, input int mwait);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] alu;
        logic       asrc, arsel, ext, pcw, rw;
        logic [1:0] npc, gpr, wd;
        int         path;
        exp_t       e;
        op = 6'h00; fn = 6'h00; alu = 5'd0; asrc = 1'b0; arsel = 1'b0; ext = 1'b0;
        pcw = 1'b0; rw = 1'b0; npc = 2'b00; gpr = 2'b00; wd = 2'b00; path = 0;
        case (name)
            "add":  begin fn = 6'h20; path = 1; end
            "sub":  begin fn = 6'h22; alu = 5'd1; path = 1; end
            "and":  begin fn = 6'h24; alu = 5'd2; path = 1; end
            "or":   begin fn = 6'h25; alu = 5'd3; path = 1; end
            "slt":  begin fn = 6'h2A; alu = 5'd4; path = 1; end
            "sll":  begin fn = 6'h00; alu = 5'd5; arsel = 1'b1; path = 1; end
            "srl":  begin fn = 6'h02; alu = 5'd6; arsel = 1'b1; path = 1; end
            "addi": begin op = 6'h08; asrc = 1'b1; ext = 1'b1; path = 2; end
            "ori":  begin op = 6'h0D; alu = 5'd3; asrc = 1'b1; path = 2; end
            "lui":  begin op = 6'h0F; alu = 5'd7; asrc = 1'b1; path = 2; end
            "lw":   begin op = 6'h23; asrc = 1'b1; ext = 1'b1; path = 3; end
            "sw":   begin op = 6'h2B; asrc = 1'b1; ext = 1'b1; path = 4; end
            "beq":  begin op = 6'h04; alu = 5'd1; pcw = zero;  npc = zero ? 2'b01 : 2'b00; end
            "bne":  begin op = 6'h05; alu = 5'd1; pcw = !zero; npc = !zero ? 2'b01 : 2'b00; end
            "j":    begin op = 6'h02; pcw = 1'b1; npc = 2'b10; end
            "jal":  begin op = 6'h03; pcw = 1'b1; npc = 2'b10; rw = 1'b1; gpr = 2'b10; wd = 2'b10; end
            "jr":   begin fn = 6'h08; pcw = 1'b1; npc = 2'b11; end
            "jalr": begin fn = 6'h09; pcw = 1'b1; npc = 2'b11; rw = 1'b1; wd = 2'b10; end
            "ill_op": begin op = 6'h3F; path = 5; end
            "ill_fn": begin fn = 6'h3F; path = 5; end
            default: $fatal(1, "unknown instruction %s", name);
        endcase

        for (int i = 0; i < fwait; i++)
            sbq.push_back({1'b0, mk(1,0,0,0,2'b00,0,0,5'd0,0,0,0,2'b00,2'b00,0,3'd0)});
        sbq.push_back({1'b1, mk(1,0,1,1,2'b00,0,0,5'd0,0,0,0,2'b00,2'b00,0,3'd0)});
        if (path == 5) begin
            sbq.push_back({rb(), mk(0,0,0,0,2'b00,0,0,5'd0,0,0,0,2'b00,2'b00,1,3'd1)});
        end else begin
            sbq.push_back({rb(), mk(0,0,0,0,2'b00,0,0,5'd0,0,0,0,2'b00,2'b00,0,3'd1)});
            sbq.push_back({rb(), mk(0,0,0,pcw,npc,rw,0,alu,asrc,arsel,ext,wd,gpr,0,3'd2)});
            if (path == 3 || path == 4) begin
                for (int i = 0; i < mwait; i++)
                    sbq.push_back({1'b0, mk(1,1,0,0,2'b00,0,path == 4,5'd0,0,0,0,2'b00,2'b00,0,3'd3)});
                sbq.push_back({1'b1, mk(1,1,0,0,2'b00,0,path == 4,5'd0,0,0,0,2'b00,2'b00,0,3'd3)});
            end
            if (path == 1)
                sbq.push_back({rb(), mk(0,0,0,0,2'b00,1,0,5'd0,0,0,0,2'b00,2'b00,0,3'd4)});
            else if (path == 2)
                sbq.push_back({rb(), mk(0,0,0,0,2'b00,1,0,5'd0,0,0,0,2'b00,2'b01,0,3'd4)});
            else if (path == 3)
                sbq.push_back({rb(), mk(0,0,0,0,2'b00,1,0,5'd0,0,0,0,2'b01,2'b01,0,3'd4)});
        end

        Op = op;
        Funct = fn;
        Zero = zero;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            mem_rdy = e.mrdy;
            @(negedge clk);
            check(name, {8'd0, obs}, {8'd0, e.vec});
            @(posedge clk);
            #1;
        end
        if (path != 5)
            exp_ret = exp_ret + 32'd1;
`ifdef MC_CTRL_PERF_EN
        check({name, " retired"}, retired, exp_ret);
`endif
    endtask

    initial begin
        #12;
        check("reset_outputs", {8'd0, obs}, 32'd0);
`ifdef MC_CTRL_PERF_EN
        check("reset_retired", retired, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_release_idle", {8'd0, obs}, 32'd0);
        @(posedge clk); #1;

        issue("add", 1'b0, 0, 0);
        issue("sub", 1'b0, 0, 0);
        issue("and", 1'b0, 1, 0);
        issue("or", 1'b0, 0, 0);
        issue("slt", 1'b0, 0, 0);
        issue("sll", 1'b0, 0, 0);
        issue("srl", 1'b0, 2, 0);
        issue("addi", 1'b0, 0, 0);
        issue("ori", 1'b0, 0, 0);
        issue("lui", 1'b0, 0, 0);
        issue("lw", 1'b0, 0, 3);
        issue("lw", 1'b0, 0, 0);
        issue("sw", 1'b0, 0, 2);
        issue("sw", 1'b0, 0, 0);
        issue("beq", 1'b1, 0, 0);
        issue("beq", 1'b0, 0, 0);
        issue("bne", 1'b0, 0, 0);
        issue("bne", 1'b1, 0, 0);
        issue("j", 1'b0, 0, 0);
        issue("jal", 1'b0, 0, 0);
        issue("jr", 1'b0, 0, 0);
        issue("jalr", 1'b0, 0, 0);
        issue("ill_op", 1'b0, 0, 0);
        issue("ill_fn", 1'b0, 0, 0);
        issue("add", 1'b0, 0, 0);

`ifdef MC_CTRL_PERF_EN
        mem_rdy = 1'b0;
        @(negedge clk);
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        exp_ret = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        issue("add", 1'b0, 0, 0);
        check("retired_wrap", retired, 32'd0);
`endif

        // Asynchronous reset while sw waits in MEM
        Op = 6'h2B;
        Funct = 6'h00;
        mem_rdy = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        mem_rdy = 1'b0;
        @(negedge clk);
        check("sw_mem_state", {29'd0, state}, 32'd3);
        check("sw_memwrite", {31'd0, MemWrite}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("async_rst_state", {29'd0, state}, 32'd0);
        check("async_rst_outputs", {8'd0, obs}, 32'd0);
`ifdef MC_CTRL_PERF_EN
        check("async_rst_retired", retired, 32'd0);
`endif
        exp_ret = 32'd0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(negedge clk);
        check("rerelease_idle", {8'd0, obs}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rerelease_fetch", {8'd0, obs},
              {8'd0, mk(1,0,0,0,2'b00,0,0,5'd0,0,0,0,2'b00,2'b00,0,3'd0)});
        @(posedge clk); #1;
        issue("add", 1'b0, 0, 0);
        @(negedge clk);
        check("final_state", {29'd0, state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
